// File: rtl/sched_pkg.sv
// Shared definitions for the microcoded schedule sequencer: state encoding,
// table-word field layout and elaboration-time width helpers.
package sched_pkg;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_RUN  = 2'd1;
    localparam state_t S_DONE = 2'd2;

    // Slot layout, LSB first: en, op, sel1, sel2, dst
    localparam int EN_OFF = 0;
    localparam int OP_OFF = 1;

    function automatic int sel1_off(int op_w);
        return 1 + op_w;
    endfunction

    function automatic int sel2_off(int op_w, int sel_w);
        return 1 + op_w + sel_w;
    endfunction

    function automatic int dst_off(int op_w, int sel_w);
        return 1 + op_w + 2 * sel_w;
    endfunction

    function automatic int fu_w(int op_w, int sel_w, int dst_w);
        return 1 + op_w + 2 * sel_w + dst_w;
    endfunction

    function automatic int word_w(int num_fu, int fu_width);
        return num_fu * fu_width + 2;
    endfunction

    function automatic int clog2(int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/sched_sequencer_if.sv
// Handshake, configuration and datapath-control bundle between the
// controlling host (master) and the sequencer (slave).
interface sched_sequencer_if
    import sched_pkg::*;
#(
    parameter int NUM_STEPS = 16,
    parameter int NUM_FU    = 3,
    parameter int OP_W      = 2,
    parameter int SEL_W     = 4,
    parameter int NUM_REGS  = 10,
    parameter int DST_W     = 4
);
    localparam int STEP_W = clog2(NUM_STEPS);
    localparam int WORD_W = word_w(NUM_FU, fu_w(OP_W, SEL_W, DST_W));

    logic                      start;
    logic                      hold;
    logic                      abort;
    logic                      cfg_we;
    logic [STEP_W-1:0]         cfg_addr;
    logic [WORD_W-1:0]         cfg_wdata;
    logic                      op_ready;
    logic [NUM_FU*OP_W-1:0]    fu_op;
    logic [NUM_FU*SEL_W-1:0]   fu_sel1;
    logic [NUM_FU*SEL_W-1:0]   fu_sel2;
    logic [NUM_REGS-1:0]       reg_en;
    logic                      result_en;
    logic                      done;
    logic                      err_conflict;
    logic                      err_overrun;

    modport master (
        output start, hold, abort, cfg_we, cfg_addr, cfg_wdata,
        input  op_ready, fu_op, fu_sel1, fu_sel2, reg_en, result_en,
               done, err_conflict, err_overrun
    );

    modport slave (
        input  start, hold, abort, cfg_we, cfg_addr, cfg_wdata,
        output op_ready, fu_op, fu_sel1, fu_sel2, reg_en, result_en,
               done, err_conflict, err_overrun
    );

endinterface

// File: rtl/sched_step_decode.sv
// Combinational decode of one table word into FU op/select fields,
// register write enables and a same-destination conflict flag.
module sched_step_decode
    import sched_pkg::*;
#(
    parameter int NUM_FU   = 3,
    parameter int OP_W     = 2,
    parameter int SEL_W    = 4,
    parameter int NUM_REGS = 10,
    parameter int DST_W    = 4
) (
    input  logic [NUM_FU*fu_w(OP_W, SEL_W, DST_W)-1:0] slots_i,
    input  logic                                       result_bit_i,
    input  logic                                       active_i,
    input  logic                                       en_allow_i,
    output logic [NUM_FU*OP_W-1:0]                     fu_op_o,
    output logic [NUM_FU*SEL_W-1:0]                    fu_sel1_o,
    output logic [NUM_FU*SEL_W-1:0]                    fu_sel2_o,
    output logic [NUM_REGS-1:0]                        reg_en_o,
    output logic                                       result_en_o,
    output logic                                       conflict_o
);
    localparam int FU_W     = fu_w(OP_W, SEL_W, DST_W);
    localparam int SEL1_OFF = sel1_off(OP_W);
    localparam int SEL2_OFF = sel2_off(OP_W, SEL_W);
    localparam int DST_OFF  = dst_off(OP_W, SEL_W);

    logic [FU_W-1:0]     slot;
    logic [DST_W-1:0]    dst;
    logic [NUM_REGS-1:0] claimed;

    // Destinations outside the register file are dropped silently
    always_comb begin
        fu_op_o    = '0;
        fu_sel1_o  = '0;
        fu_sel2_o  = '0;
        conflict_o = 1'b0;
        claimed    = '0;
        slot       = '0;
        dst        = '0;
        for (int f = 0; f < NUM_FU; f++) begin
            slot = slots_i[f*FU_W +: FU_W];
            if (active_i && slot[EN_OFF]) begin
                fu_op_o[f*OP_W +: OP_W]     = slot[OP_OFF +: OP_W];
                fu_sel1_o[f*SEL_W +: SEL_W] = slot[SEL1_OFF +: SEL_W];
                fu_sel2_o[f*SEL_W +: SEL_W] = slot[SEL2_OFF +: SEL_W];
                dst = slot[DST_OFF +: DST_W];
                if (int'(dst) < NUM_REGS) begin
                    if (claimed[dst]) conflict_o = 1'b1;
                    claimed[dst] = 1'b1;
                end
            end
        end
        reg_en_o    = en_allow_i ? claimed : '0;
        result_en_o = en_allow_i & result_bit_i;
    end

endmodule

// File: rtl/sched_sequencer.sv
// Microcoded datapath sequencer: walks a writable step table from start to
// the last-flagged step, driving FU controls and register enables per step.
module sched_sequencer
    import sched_pkg::*;
#(
    parameter int NUM_STEPS = 16,
    parameter int NUM_FU    = 3,
    parameter int OP_W      = 2,
    parameter int SEL_W     = 4,
    parameter int NUM_REGS  = 10,
    parameter int DST_W     = 4
) (
    input logic               clk,
    input logic               rst,
    sched_sequencer_if.slave  bus
);
    localparam int FU_W    = fu_w(OP_W, SEL_W, DST_W);
    localparam int WORD_W  = word_w(NUM_FU, FU_W);
    localparam int STEP_W  = clog2(NUM_STEPS);
    localparam int SLOTS_W = NUM_FU * FU_W;

    state_t              state_q, state_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic                err_conflict_q, err_conflict_d;
    logic                err_overrun_q, err_overrun_d;
    logic [WORD_W-1:0]   table_q [NUM_STEPS];

    logic [WORD_W-1:0]         cur_word;
    logic                      run_active;
    logic                      conflict;
    logic                      cfg_write;
    logic [NUM_FU*OP_W-1:0]    fu_op;
    logic [NUM_FU*SEL_W-1:0]   fu_sel1;
    logic [NUM_FU*SEL_W-1:0]   fu_sel2;
    logic [NUM_REGS-1:0]       reg_en;
    logic                      result_en;

    assign cur_word   = table_q[step_q];
    assign run_active = (state_q == S_RUN);
    assign cfg_write  = bus.cfg_we && (state_q == S_IDLE);

    sched_step_decode #(
        .NUM_FU   (NUM_FU),
        .OP_W     (OP_W),
        .SEL_W    (SEL_W),
        .NUM_REGS (NUM_REGS),
        .DST_W    (DST_W)
    ) u_decode (
        .slots_i      (cur_word[SLOTS_W-1:0]),
        .result_bit_i (cur_word[SLOTS_W]),
        .active_i     (run_active),
        .en_allow_i   (run_active && !bus.hold && !bus.abort),
        .fu_op_o      (fu_op),
        .fu_sel1_o    (fu_sel1),
        .fu_sel2_o    (fu_sel2),
        .reg_en_o     (reg_en),
        .result_en_o  (result_en),
        .conflict_o   (conflict)
    );

    // abort outranks hold, and hold outranks both last and table overrun
    always_comb begin
        state_d        = state_q;
        step_d         = step_q;
        err_conflict_d = err_conflict_q;
        err_overrun_d  = err_overrun_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d        = S_RUN;
                    step_d         = '0;
                    err_conflict_d = 1'b0;
                    err_overrun_d  = 1'b0;
                end
            end
            S_RUN: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                    step_d  = '0;
                end else begin
                    if (conflict) err_conflict_d = 1'b1;
                    if (!bus.hold) begin
                        if (cur_word[WORD_W-1]) begin
                            state_d = S_DONE;
                        end else if (step_q == STEP_W'(NUM_STEPS-1)) begin
                            state_d       = S_DONE;
                            err_overrun_d = 1'b1;
                        end else begin
                            step_d = step_q + 1'b1;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                step_d  = '0;
            end
            default: begin
                state_d = S_IDLE;
                step_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            step_q         <= '0;
            err_conflict_q <= 1'b0;
            err_overrun_q  <= 1'b0;
            for (int i = 0; i < NUM_STEPS; i++) table_q[i] <= '0;
        end else begin
            state_q        <= state_d;
            step_q         <= step_d;
            err_conflict_q <= err_conflict_d;
            err_overrun_q  <= err_overrun_d;
            if (cfg_write) table_q[bus.cfg_addr] <= bus.cfg_wdata;
        end
    end

    assign bus.op_ready     = (state_q == S_IDLE);
    assign bus.done         = (state_q == S_DONE);
    assign bus.err_conflict = err_conflict_q;
    assign bus.err_overrun  = err_overrun_q;
    assign bus.fu_op        = fu_op;
    assign bus.fu_sel1      = fu_sel1;
    assign bus.fu_sel2      = fu_sel2;
    assign bus.reg_en       = reg_en;
    assign bus.result_en    = result_en;

endmodule

// File: tb/tb_sched_sequencer.sv
// Scoreboard bench for sched_sequencer: stimulus queues cycle-stamped
// expectations, a negedge monitor pops and compares them.
module tb_sched_sequencer;
    import sched_pkg::*;

    typedef struct {
        string       name;
        int          cyc;
        logic [9:0]  reg_en;
        logic        res;
        logic        done;
        logic        rdy;
        logic        errc;
        logic        erro;
        logic [11:0] sel1;
        logic [5:0]  op;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t expQ[$];
    exp_t e;

    logic [46:0] sched [6];
    logic [9:0]  stepReg [6] = '{10'h026, 10'h008, 10'h040, 10'h080, 10'h300, 10'h001};
    logic [11:0] stepSel [6] = '{12'h221, 12'h003, 12'h050, 12'h700, 12'h0A9, 12'hB00};
    logic [5:0]  stepOp  [6] = '{6'h14, 6'h02, 6'h0C, 6'h10, 6'h09, 6'h00};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sched_sequencer_if #(
        .NUM_STEPS(16), .NUM_FU(3), .OP_W(2), .SEL_W(4), .NUM_REGS(10), .DST_W(4)
    ) bus ();

    sched_sequencer #(
        .NUM_STEPS(16), .NUM_FU(3), .OP_W(2), .SEL_W(4), .NUM_REGS(10), .DST_W(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [14:0] slot(int en, int op, int s1, int s2, int dst);
        return {4'(dst), 4'(s2), 4'(s1), 2'(op), 1'(en)};
    endfunction

    function automatic logic [46:0] word(logic [14:0] f0, logic [14:0] f1, logic [14:0] f2,
                                         logic res, logic last);
        return {last, res, f2, f1, f0};
    endfunction

    task automatic checkOutput(string name, int c, logic [31:0] act, logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, c, act, expv);
        end
    endtask

    task automatic pushExp(string name, int c, logic [9:0] re, logic res, logic dn, logic rdy,
                           logic ec, logic eo, logic [11:0] s1, logic [5:0] op);
        exp_t x;
        x.name = name; x.cyc = c; x.reg_en = re; x.res = res; x.done = dn; x.rdy = rdy;
        x.errc = ec; x.erro = eo; x.sel1 = s1; x.op = op;
        expQ.push_back(x);
    endtask

    task automatic pushIdle(string name, int c, logic ec, logic eo);
        pushExp(name, c, 10'h0, 1'b0, 1'b0, 1'b1, ec, eo, 12'h0, 6'h0);
    endtask

    task automatic pushDone(string name, int c, logic ec, logic eo);
        pushExp(name, c, 10'h0, 1'b0, 1'b1, 1'b0, ec, eo, 12'h0, 6'h0);
    endtask

    task automatic pushStep(string name, int c, int k, logic en);
        pushExp(name, c, en ? stepReg[k] : 10'h0, en && (k == 5), 1'b0, 1'b0, 1'b0, 1'b0,
                stepSel[k], stepOp[k]);
    endtask

    task automatic applyStimulus(logic st, logic hd, logic ab, logic we,
                                 logic [3:0] addr, logic [46:0] wd);
        bus.start     = st;
        bus.hold      = hd;
        bus.abort     = ab;
        bus.cfg_we    = we;
        bus.cfg_addr  = addr;
        bus.cfg_wdata = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 47'h0);
    endtask

    always @(negedge clk) begin
        while (expQ.size() > 0 && expQ[0].cyc <= cyc) begin
            e = expQ.pop_front();
            if (e.cyc < cyc) begin
                checkOutput({e.name, ".missed"}, cyc, 32'(e.cyc), 32'(cyc));
            end else begin
                checkOutput({e.name, ".reg_en"}, cyc, 32'(bus.reg_en), 32'(e.reg_en));
                checkOutput({e.name, ".result_en"}, cyc, 32'(bus.result_en), 32'(e.res));
                checkOutput({e.name, ".done"}, cyc, 32'(bus.done), 32'(e.done));
                checkOutput({e.name, ".op_ready"}, cyc, 32'(bus.op_ready), 32'(e.rdy));
                checkOutput({e.name, ".err_conflict"}, cyc, 32'(bus.err_conflict), 32'(e.errc));
                checkOutput({e.name, ".err_overrun"}, cyc, 32'(bus.err_overrun), 32'(e.erro));
                checkOutput({e.name, ".fu_sel1"}, cyc, 32'(bus.fu_sel1), 32'(e.sel1));
                checkOutput({e.name, ".fu_op"}, cyc, 32'(bus.fu_op), 32'(e.op));
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int base;

        sched[0] = word(slot(1, 0, 1, 2, 1), slot(1, 1, 2, 0, 2), slot(1, 1, 2, 1, 5), 1'b0, 1'b0);
        sched[1] = word(slot(1, 2, 3, 4, 3), slot(0, 3, 15, 15, 9), 15'h0, 1'b0, 1'b0);
        sched[2] = word(15'h0, slot(1, 3, 5, 6, 6), 15'h0, 1'b0, 1'b0);
        sched[3] = word(15'h0, 15'h0, slot(1, 1, 7, 8, 7), 1'b0, 1'b0);
        sched[4] = word(slot(1, 1, 9, 1, 8), slot(1, 2, 10, 2, 9), 15'h0, 1'b0, 1'b0);
        sched[5] = word(15'h0, 15'h0, slot(1, 0, 11, 3, 0), 1'b1, 1'b1);

        // Reset state
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        base = cyc;
        pushIdle("reset", base, 1'b0, 1'b0);
        idle(1);

        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'(i), sched[i]);

        // Plain six-step run
        base = cyc;
        pushIdle("run.c0", base, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) pushStep("run.step", base + 1 + k, k, 1'b1);
        pushDone("run.done", base + 7, 1'b0, 1'b0);
        pushIdle("run.ready", base + 8, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 47'h0);
        idle(9);

        // Three-cycle hold on step 2
        base = cyc;
        pushIdle("hold.c0", base, 1'b0, 1'b0);
        pushStep("hold.step", base + 1, 0, 1'b1);
        pushStep("hold.step", base + 2, 1, 1'b1);
        for (int h = 0; h < 3; h++) pushStep("hold.frozen", base + 3 + h, 2, 1'b0);
        for (int k = 2; k < 6; k++) pushStep("hold.step", base + 4 + k, k, 1'b1);
        pushDone("hold.done", base + 10, 1'b0, 1'b0);
        pushIdle("hold.ready", base + 11, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 47'h0);
        idle(2);
        for (int h = 0; h < 3; h++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 47'h0);
        idle(7);

        // Abort on step 3
        base = cyc;
        pushStep("abort.step", base + 3, 2, 1'b1);
        pushStep("abort.cycle", base + 4, 3, 1'b0);
        for (int k = 5; k < 11; k++) pushIdle("abort.idle", base + k, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 47'h0);
        idle(3);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 47'h0);
        idle(7);

        // FU0 and FU2 both write r4
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'h0,
                      word(slot(1, 1, 1, 0, 4), 15'h0, slot(1, 2, 3, 0, 4), 1'b0, 1'b1));
        base = cyc;
        pushExp("conflict.step", base + 1, 10'h010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h301, 6'h21);
        pushDone("conflict.done", base + 2, 1'b1, 1'b0);
        pushIdle("conflict.sticky", base + 3, 1'b1, 1'b0);
        pushIdle("conflict.sticky", base + 4, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 47'h0);
        idle(5);

        // Write+start together, write during RUN ignored, start in DONE ignored
        base = cyc;
        pushIdle("wrstart.c0", base, 1'b1, 1'b0);
        for (int k = 0; k < 6; k++) pushStep("wrstart.step", base + 1 + k, k, 1'b1);
        pushDone("wrstart.done", base + 7, 1'b0, 1'b0);
        pushIdle("donestart.ready", base + 8, 1'b0, 1'b0);
        pushIdle("donestart.ignored", base + 9, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'h0, sched[0]);
        idle(1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'h5, 47'h0);
        idle(4);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 47'h0);
        idle(3);

        // Reset mid-run clears state and table
        base = cyc;
        pushStep("rstrun.step", base + 3, 2, 1'b1);
        pushIdle("rstrun.after", base + 4, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 47'h0);
        idle(2);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(1);

        // Empty table runs to the end and flags overrun
        base = cyc;
        pushIdle("overrun.c0", base, 1'b0, 1'b0);
        pushExp("overrun.first", base + 1, 10'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0, 6'h0);
        pushExp("overrun.mid", base + 8, 10'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0, 6'h0);
        pushExp("overrun.lastrow", base + 16, 10'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0, 6'h0);
        pushDone("overrun.done", base + 17, 1'b0, 1'b1);
        pushIdle("overrun.ready", base + 18, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 47'h0);
        idle(20);

        checkOutput("scoreboard.leftover", cyc, 32'(expQ.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sched_sequencer.md
Name: sched_sequencer

Overview:
- Microcode-driven successor to the fixed-schedule datapath controller: the schedule (per-step FU ops, operand selects, destination register writes, result capture) lives in a writable step table rather than hardcoded states.
- Sits between the top-level start/done handshake and the shared datapath (FU muxes, FU op codes, register-file enables).
- Parametrised in step count, FU count and register count; adds hold (stall), abort and error flags.

Parameters:
- NUM_STEPS, 16, max schedule length (table depth)
- NUM_FU, 3, number of functional units driven
- OP_W, 2, op-code width per FU
- SEL_W, 4, operand-select width per FU input
- NUM_REGS, 10, datapath registers with write enables
- DST_W, 4, destination-index width; must satisfy 2**DST_W >= NUM_REGS
- derived: FU_W = 1+OP_W+2*SEL_W+DST_W; WORD_W = NUM_FU*FU_W+2; STEP_W = clog2(NUM_STEPS)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin schedule; accepted only in IDLE
- hold  in  1  stall: freeze step, suppress enables
- abort  in  1  terminate run, back to IDLE, no done
- cfg_we  in  1  table write strobe
- cfg_addr  in  STEP_W  table write address
- cfg_wdata  in  WORD_W  table word
- op_ready  out  1  high in IDLE
- fu_op  out  NUM_FU*OP_W  per-FU op, FU0 in LSBs
- fu_sel1  out  NUM_FU*SEL_W  per-FU operand-1 select
- fu_sel2  out  NUM_FU*SEL_W  per-FU operand-2 select
- reg_en  out  NUM_REGS  datapath register write enables
- result_en  out  1  result register capture
- done  out  1  one-cycle completion pulse
- err_conflict  out  1  sticky: two FUs targeted same reg in one step
- err_overrun  out  1  sticky: table ended without last flag

Behaviour:
- Table word, FU f at bits [f*FU_W +: FU_W]; within a slot, LSB first: en, op, sel1, sel2, dst. Bit NUM_FU*FU_W = result_en. Bit NUM_FU*FU_W+1 = last.
- Table is a register array of NUM_STEPS words, cleared to 0 on rst. Write on cfg_we only when state==IDLE; writes in other states ignored. Write with start in the same cycle: the write lands and the run starts; step 0 reads the new contents.
- States: IDLE, RUN, DONE (shared encoding). rst: state=IDLE, step=0, errors=0, all outputs 0 except op_ready=1.
- IDLE: op_ready=1. start -> RUN, step=0, err flags cleared. Next cycle step 0 is active. Same latency as the predecessor.
- RUN: outputs decode combinationally from table[step]. For each FU with en=1: fu_op/sel = slot fields, reg_en[dst]=1; dst>=NUM_REGS gives no enable. FU with en=0 drives op/sel=0. result_en = word bit.
- Two enabled FUs with the same valid dst: reg_en stays a single bit (OR), err_conflict set next cycle.
- hold=1 in RUN: step and state frozen; reg_en=0 and result_en=0; op/sel still driven.
- If hold=0 and last=1: -> DONE. If hold=0 and step==NUM_STEPS-1 without last: -> DONE and set err_overrun. Otherwise step+1.
- abort=1 in RUN: priority over hold and last. All enables 0 that cycle, next state IDLE, step=0, no done pulse. abort in IDLE/DONE is ignored.
- DONE: done=1 for exactly one cycle, all enables 0, -> IDLE. start is ignored while in DONE.
- A schedule of N steps (last on step N-1): start accepted at cycle 0, steps active cycles 1..N, done at cycle N+1, op_ready at N+2. Each hold cycle adds 1.
- rst mid-run: returns to IDLE, clears the table and err flags. No done pulse.

Decomposition:
- Shared package sched_pkg: state encoding (S_IDLE/S_RUN/S_DONE), field offset/width localparams and functions for FU_W/WORD_W, and a clog2 helper.
- One natural sub-module: sched_step_decode. It is combinational: word + run-enable in, fu_op/fu_sel1/fu_sel2/reg_en/result_en/conflict out. It is instantiated once.
- The top holds the FSM, step counter, table, err flags and cfg port.

Test Plan:
- Program the predecessor's 6-step schedule: step0 FU0 op0 sel1/2 -> dst1, FU1 op1 sel2/0 -> dst2, FU2 op1 sel2/1 -> dst5; ... step5 result bit, last=1. Start -> reg_en = 0x026 at cycle 1, done at cycle 7, op_ready at cycle 8.
- hold for 3 cycles during step 2 -> reg_en=0 and step frozen during hold, fu_sel steady; done delayed to cycle 10.
- abort at step 3 -> reg_en=0 that cycle, IDLE next cycle, done never asserted, op_ready=1.
- Step with FU0 and FU2 both dst=4 -> reg_en=0x010, err_conflict=1 next cycle and held until the next start.
- Table cleared by reset, no last flag, start -> 16 steps of zero outputs, done at cycle 17, err_overrun=1.
- cfg_we during RUN to step 5 -> table unchanged. start asserted in DONE -> ignored, no second run. cfg_we with start in IDLE -> new word used at step 0.
